cpu_mul_pipe: RTL and testbench



---
 rtl/cpu_mul_pipe.sv | 166 ++++++++++++++++
 tb/tb_cpu_mul_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mul_pipe.sv
// rtl/cpu_mul_pipe.sv - three-stage stallable integer multiplier (MUL / MULXSS / MULXSU / MULXUU)
//
// Optional feature macro: CPU_MUL_HI_EN
//   defined   : full build; all four in_op encodings; high-word results with sign handling
//   undefined : low-word-only build; in_op ignored, out_result = product[DATA_W-1:0]
//
// Ports:
//   clk        clock, all state on rising edge
//   reset_n    asynchronous active-low reset, clears every register
//   stall      1 = every pipeline register (data and valid) holds
//   in_valid   operation present on in_* (accepted when stall=0)
//   in_op      00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//   in_src1    multiplicand
//   in_src2    multiplier
//   in_tag     sideband returned with the result
//   out_valid  out_result/out_tag valid
//   out_result selected product word
//   out_tag    tag of the result
//   busy       any stage holds a valid operation
module cpu_mul_pipe #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 16,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int N   = DATA_W / LANE_W;
    localparam int PW  = 2 * DATA_W;
    localparam int PPW = 2 * LANE_W;

`ifdef CPU_MUL_HI_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    // S1: operand stage
    logic              s1_valid;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    // S2: partial-product stage
    logic              s2_valid;
    logic [TAG_W-1:0]  s2_tag;
    logic [PPW-1:0]    s2_pp [N*N];

    logic [PW-1:0]     sum;
    logic [DATA_W-1:0] sel_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_tag   <= in_tag;
            s1_a     <= in_src1;
            s1_b     <= in_src2;
        end
    end

    // Low-word build only needs lanes whose product lands below bit DATA_W;
    // the remaining entries stay at their reset value of zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            for (int k = 0; k < N * N; k++) s2_pp[k] <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (HI_EN || (i + j < N)) begin
                        s2_pp[i*N+j] <= PPW'(s1_a[i*LANE_W +: LANE_W]) *
                                        PPW'(s1_b[j*LANE_W +: LANE_W]);
                    end
                end
            end
        end
    end

`ifdef CPU_MUL_HI_EN
    // The sign bit of each DATA_W+1 extended operand: src1 signed for 01/10,
    // src2 signed for 01 only.
    logic [1:0]        s1_op;
    logic              s1_a_s;
    logic              s1_b_s;
    logic [1:0]        s2_op;
    logic [DATA_W-1:0] s2_corr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_op   <= '0;
            s1_a_s  <= 1'b0;
            s1_b_s  <= 1'b0;
            s2_op   <= '0;
            s2_corr <= '0;
        end else if (!stall) begin
            s1_op   <= in_op;
            s1_a_s  <= ((in_op == 2'b01) || (in_op == 2'b10)) && in_src1[DATA_W-1];
            s1_b_s  <= (in_op == 2'b01) && in_src2[DATA_W-1];
            s2_op   <= s1_op;
            // Both corrections are scaled by 2^DATA_W, so only their low
            // DATA_W bits survive modulo 2^(2*DATA_W).
            s2_corr <= (s1_a_s ? s1_b : '0) + (s1_b_s ? s1_a : '0);
        end
    end
`else
    logic unused_op;
    logic unused_hi;
    assign unused_op = ^in_op;
    assign unused_hi = ^sum[PW-1:DATA_W];
`endif

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = sum + (PW'(s2_pp[i*N+j]) << (LANE_W * (i + j)));
            end
        end
`ifdef CPU_MUL_HI_EN
        sum = sum - {s2_corr, {DATA_W{1'b0}}};
`endif
    end

`ifdef CPU_MUL_HI_EN
    assign sel_word = (s2_op == 2'b00) ? sum[DATA_W-1:0] : sum[PW-1:DATA_W];
`else
    assign sel_word = sum[DATA_W-1:0];
`endif

    // S3: result stage; result and tag only change when a valid op leaves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_result <= sel_word;
                out_tag    <= s2_tag;
            end
        end
    end

    assign busy = s1_valid | s2_valid | out_valid;

endmodule

// File: tb/tb_cpu_mul_pipe.sv
// tb/tb_cpu_mul_pipe.sv - scoreboard bench for cpu_mul_pipe
module tb_cpu_mul_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic edge_stall = 1'b0;

    cpu_mul_pipe dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .in_valid   (in_valid),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef CPU_MUL_HI_EN
        logic signed [32:0] ea;
        logic signed [32:0] eb;
        logic signed [65:0] p;
        ea = ((op == 2'b01) || (op == 2'b10)) ? {a[31], a} : {1'b0, a};
        eb = (op == 2'b01) ? {b[31], b} : {1'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
`else
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
`endif
    endfunction

    // Scoreboard push on every accepted op; remember whether this edge stalled.
    always @(posedge clk) begin
        edge_stall = stall;
        if (reset_n && in_valid && !stall)
            sb.push_back('{res: model(in_op, in_src1, in_src2), tag: in_tag});
    end

    // A held output during a stall is the same result, not a new one.
    always @(negedge clk) begin
        if (reset_n && out_valid && !edge_stall) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", (sb.size() != 0), 1'b1);
            end else begin
                mon_e = sb.pop_front();
                check("result", out_result, mon_e.res);
                check("tag", out_tag, mon_e.tag);
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t, input logic s);
        in_valid = v;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = t;
        stall    = s;
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_result", out_result, 32'h0);
        check("rst_tag", out_tag, 5'd0);
        check("rst_busy", busy, 1'b0);
        cyc;
        reset_n = 1'b1;
        cyc;

        // All four ops back-to-back on all-ones operands
        for (int c = 0; c < 8; c++) begin
            cyc;
            check("t1_valid", out_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check("t1_tag", out_tag, 5'(c - 3));
            if (c < 4) drive(1'b1, 2'(c), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(c), 1'b0);
            else       drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        end

        // Most-negative operand corners
        for (int c = 0; c < 8; c++) begin
            cyc;
            case (c)
                0: drive(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd10, 1'b0);
                1: drive(1'b1, 2'b11, 32'h8000_0000, 32'h8000_0000, 5'd11, 1'b0);
                2: drive(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 5'd12, 1'b0);
                3: drive(1'b1, 2'b10, 32'h8000_0000, 32'h0000_0002, 5'd13, 1'b0);
                4: drive(1'b1, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 1'b0);
                5: drive(1'b1, 2'b10, 32'hFFFF_FFFE, 32'h8000_0001, 5'd15, 1'b0);
                default: drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
            endcase
        end
        repeat (4) cyc;

        // Two stall cycles one cycle after the first accept
        for (int c = 0; c < 10; c++) begin
            int t;
            cyc;
            check("t3_valid", out_valid, (c >= 5 && c <= 8));
            if (c >= 5 && c <= 8) check("t3_tag", out_tag, 5'(c - 5));
            t = (c == 0) ? 0 : (c <= 3) ? 1 : c - 2;
            if (c <= 5) drive(1'b1, 2'b00, 32'(t * 3 + 1), 32'(t * 5 + 2), 5'(t), (c == 1 || c == 2));
            else        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        end

        // Stall while a result sits on the output
        for (int c = 0; c < 7; c++) begin
            cyc;
            check("t3b_valid", out_valid, (c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) check("t3b_tag", out_tag, 5'd5);
            if (c == 4) check("t3b_busy", busy, 1'b1);
            if (c == 0) drive(1'b1, 2'b00, 32'd1000, 32'd3, 5'd5, 1'b0);
            else        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, (c == 3 || c == 4));
        end

        // Held request under stall is accepted once
        for (int c = 0; c < 8; c++) begin
            cyc;
            check("t4_valid", out_valid, (c == 6));
            if (c == 6) check("t4_tag", out_tag, 5'd9);
            if (c <= 3) drive(1'b1, 2'b00, 32'd123, 32'd456, 5'd9, (c <= 2));
            else        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        end
        check("t4_sb_empty", sb.size(), 0);

        // Asynchronous reset with operations in flight
        for (int c = 0; c < 4; c++) begin
            cyc;
            if (c < 3) drive(1'b1, 2'b00, 32'(100 + c), 32'd200, 5'(c + 1), 1'b0);
            else       drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        end
        check("t5_pre_valid", out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_result", out_result, 32'h0);
        check("t5_rst_tag", out_tag, 5'd0);
        check("t5_rst_busy", busy, 1'b0);
        sb.delete();
        #1 reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc;
            check("t5_valid", out_valid, (c == 3));
            if (c == 0) check("t5_busy", busy, 1'b0);
            if (c == 3) begin
                check("t5_result", out_result, 32'h0000_002A);
                check("t5_tag", out_tag, 5'd4);
            end
            if (c == 0) drive(1'b1, 2'b00, 32'd7, 32'd6, 5'd4, 1'b0);
            else        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        end

        repeat (3) cyc;
        check("sb_drained", sb.size(), 0);
        check("end_busy", busy, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
